// File: rtl/gate_truth_checker.sv
// gate_truth_checker: walks {a,b} through 00..11, samples f after a settle delay and scores it against exp_tt.
// Optional mismatch_mask output when GATE_CHECK_MASK_EN is defined.
module gate_truth_checker #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] exp_tt,
  input  logic       f,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] first_err_vec
`ifdef GATE_CHECK_MASK_EN
  ,
  output logic [3:0] mismatch_mask
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  logic [1:0] state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] tt_q, tt_d;
  logic [2:0] err_q, err_d;
  logic [1:0] first_q, first_d;
  logic pass_q, pass_d;
  logic go, mism;
`ifdef GATE_CHECK_MASK_EN
  logic [3:0] mask_q, mask_d;
  assign mismatch_mask = mask_q;
`endif
  assign go = start && state_q != RUN;
  // an X on f must count as a mismatch, hence the case-equality compare
  assign mism = !(f === tt_q[vec_q]);
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    cnt_d = cnt_q;
    tt_d = tt_q;
    err_d = err_q;
    first_d = first_q;
    pass_d = pass_q;
`ifdef GATE_CHECK_MASK_EN
    mask_d = mask_q;
`endif
    if (go) begin
      state_d = RUN;
      vec_d = 2'b00;
      cnt_d = RELOAD;
      tt_d = exp_tt;
      err_d = 3'd0;
      first_d = 2'b00;
      pass_d = 1'b0;
`ifdef GATE_CHECK_MASK_EN
      mask_d = 4'b0000;
`endif
    end else if (state_q == RUN) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        if (mism) begin
          err_d = err_q + 3'd1;
          first_d = err_q == 3'd0 ? vec_q : first_q;
`ifdef GATE_CHECK_MASK_EN
          mask_d[vec_q] = 1'b1;
`endif
        end
        if (vec_q != 2'b11) begin
          vec_d = vec_q + 2'b01;
          cnt_d = RELOAD;
        end else begin
          state_d = DONE;
          pass_d = err_d == 3'd0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q <= 2'b00;
      cnt_q <= '0;
      tt_q <= 4'b0000;
      err_q <= 3'd0;
      first_q <= 2'b00;
      pass_q <= 1'b0;
`ifdef GATE_CHECK_MASK_EN
      mask_q <= 4'b0000;
`endif
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      cnt_q <= cnt_d;
      tt_q <= tt_d;
      err_q <= err_d;
      first_q <= first_d;
      pass_q <= pass_d;
`ifdef GATE_CHECK_MASK_EN
      mask_q <= mask_d;
`endif
    end
  end
  assign a = vec_q[1];
  assign b = vec_q[0];
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign pass = pass_q;
  assign err_count = err_q;
  assign first_err_vec = first_q;
endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker: table-driven gate checks on a SETTLE_CYCLES=4 instance plus a SETTLE_CYCLES=1 instance.
module tb_gate_truth_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, start2 = 1'b0;
  logic [3:0] exp_tt = 4'b0001;
  logic [2:0] mode = 3'd0;
  logic f, f2;
  logic a, b, busy, done, pass, a2, b2, busy2, done2, pass2;
  logic [2:0] err_count, err2;
  logic [1:0] first_err_vec, first2;
  logic [3:0] mask, mask2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  gate_truth_checker #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .exp_tt(exp_tt), .f(f), .a(a), .b(b),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_vec(first_err_vec)
`ifdef GATE_CHECK_MASK_EN
    , .mismatch_mask(mask)
`endif
  );
  gate_truth_checker #(.SETTLE_CYCLES(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .exp_tt(4'b0001), .f(f2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_err_vec(first2)
`ifdef GATE_CHECK_MASK_EN
    , .mismatch_mask(mask2)
`endif
  );
`ifndef GATE_CHECK_MASK_EN
  assign mask = 4'b0000;
  assign mask2 = 4'b0000;
`endif
  always_comb begin
    case (mode)
      3'd0: f = ~(a | b);
      3'd1: f = 1'b0;
      3'd2: f = 1'b1;
      3'd3: f = a | b;
      3'd4: f = a & b;
      3'd5: f = a ^ b;
      default: f = ~(a & b);
    endcase
  end
  assign f2 = a2 | b2;
  typedef struct {
    string name;
    logic [2:0] mode;
    logic [3:0] tt;
    logic [2:0] err;
    logic [1:0] first;
    logic pass;
    logic [3:0] mask;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic run1(input bit inject, output int n, output int walk_bad);
    n = 0;
    walk_bad = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && n < 40) begin
      if (!busy || {a, b} != 2'(n / 4)) walk_bad++;
      if (inject && n == 5) begin
        start = 1'b1;
        exp_tt = 4'b1111;
      end else if (inject && n == 6) begin
        start = 1'b0;
        exp_tt = 4'b0001;
      end
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    int n, wb;
    tbl[0] = '{"nor",      3'd0, 4'b0001, 3'd0, 2'b00, 1'b1, 4'b0000};
    tbl[1] = '{"tie0",     3'd1, 4'b0001, 3'd1, 2'b00, 1'b0, 4'b0001};
    tbl[2] = '{"tie1",     3'd2, 4'b0001, 3'd3, 2'b01, 1'b0, 4'b1110};
    tbl[3] = '{"or_as_nor",3'd3, 4'b0001, 3'd4, 2'b00, 1'b0, 4'b1111};
    tbl[4] = '{"and",      3'd4, 4'b1000, 3'd0, 2'b00, 1'b1, 4'b0000};
    tbl[5] = '{"xor",      3'd5, 4'b0110, 3'd0, 2'b00, 1'b1, 4'b0000};
    tbl[6] = '{"and_as_xor",3'd4, 4'b0110, 3'd3, 2'b01, 1'b0, 4'b1110};
    tbl[7] = '{"nand_as_xnor",3'd6, 4'b1001, 3'd3, 2'b01, 1'b0, 4'b1110};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_ab", {30'd0, a, b}, 0);
    chk("reset_flags", {29'd0, busy, done, pass}, 0);
    chk("reset_err", err_count, 0);
    chk("reset_first", first_err_vec, 0);
    chk("reset_mask", mask, 0);
    for (int i = 0; i < 8; i++) begin
      mode = tbl[i].mode;
      exp_tt = tbl[i].tt;
      run1(1'b0, n, wb);
      chk({tbl[i].name, "_latency"}, n, 16);
      chk({tbl[i].name, "_walk"}, wb, 0);
      chk({tbl[i].name, "_done"}, {30'd0, done, busy}, 2);
      chk({tbl[i].name, "_err"}, err_count, tbl[i].err);
      chk({tbl[i].name, "_pass"}, pass, tbl[i].pass);
      if (tbl[i].err != 0) chk({tbl[i].name, "_first"}, first_err_vec, tbl[i].first);
`ifdef GATE_CHECK_MASK_EN
      chk({tbl[i].name, "_mask"}, mask, tbl[i].mask);
`endif
      chk({tbl[i].name, "_ab_hold"}, {30'd0, a, b}, 3);
    end
    mode = 3'd0;
    exp_tt = 4'b0001;
    run1(1'b1, n, wb);
    chk("ignore_latency", n, 16);
    chk("ignore_walk", wb, 0);
    chk("ignore_pass", pass, 1);
    chk("ignore_err", err_count, 0);
    start = 1'b1;
    @(negedge clk);
    chk("restart_done_low", {30'd0, done, busy}, 1);
    chk("restart_ab", {30'd0, a, b}, 0);
    chk("restart_pass", pass, 0);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ab", {30'd0, a, b}, 0);
    chk("abort_flags", {29'd0, busy, done, pass}, 0);
    chk("abort_err", err_count, 0);
    repeat (20) @(negedge clk);
    chk("abort_no_done", done, 0);
    mode = 3'd2;
    run1(1'b0, n, wb);
    chk("post_abort_tie1_err", err_count, 3);
    mode = 3'd0;
    run1(1'b0, n, wb);
    chk("post_abort_latency", n, 16);
    chk("post_abort_pass", pass, 1);
    chk("post_abort_err", err_count, 0);
    n = 0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    while (!done2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("s1_latency", n, 4);
    chk("s1_err", err2, 4);
    chk("s1_first", first2, 0);
    chk("s1_pass", pass2, 0);
`ifdef GATE_CHECK_MASK_EN
    chk("s1_mask", mask2, 4'b1111);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
- Self-checking harness for any 2-input combinational gate (NOR, NAND, AND, OR, XOR, XNOR) in the test-logic library.
- Drives the four input vectors to the gate under test in the order 00, 01, 10, 11, given as {a,b}.
- Samples the gate output after a settle interval and compares it against a 4-bit expected truth table.
- Reports mismatch count, first failing vector and pass/fail, so gate checks run in hardware instead of by reading $monitor output.

Parameters:
- SETTLE_CYCLES, default 4: clock cycles between applying a vector and sampling f. Legal range 1..255.
- CNT_W, default 8: width of the settle counter. Must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  level-sampled; begins a check when the block is idle or done
- exp_tt  input  4  expected output; bit index = {a,b} (NOR = 4'b0001); captured on start
- f  input  1  output of the gate under test
- a  output  1  gate input A
- b  output  1  gate input B
- busy  output  1  high while a check is running
- done  output  1  high in DONE until the next start or reset
- pass  output  1  done && err_count==0
- err_count  output  3  number of mismatching vectors, 0..4
- first_err_vec  output  2  {a,b} of the first mismatch; valid only when err_count!=0

Behaviour:
- One clock domain. Reset is synchronous and active-high; rst is sampled on the rising edge of clk.
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_count=0, first_err_vec=0, state=IDLE. Internal registers: vector index=0, settle counter=0, captured table=0.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at an edge:
  - capture exp_tt;
  - clear err_count and first_err_vec;
  - drive {a,b}=00;
  - load counter with SETTLE_CYCLES-1;
  - go to RUN with busy=1, done=0.
- RUN, counter!=0: decrement; a and b hold.
- RUN, counter==0 (the sample edge): compare f against captured_tt[{a,b}].
  - On a mismatch, increment err_count. If err_count was 0, load first_err_vec={a,b}.
  - If {a,b}!=11, advance {a,b} by 1 at the same edge and reload the counter with SETTLE_CYCLES-1.
  - If {a,b}==11, go to DONE: busy=0, done=1. a and b hold at 11.
- Timing: f is sampled exactly SETTLE_CYCLES edges after its vector was applied. done rises 4*SETTLE_CYCLES edges after the start edge (16 cycles at the default).
- pass is registered: it equals (err_count==0) in DONE and is 0 otherwise.
- start while in RUN is ignored. Changes on exp_tt during RUN are ignored.
- start held high in DONE restarts on the next edge, so done lasts one cycle. In IDLE, start held high simply starts the check.
- rst during RUN aborts the check: all outputs return to reset values on that edge, and done is never asserted for the aborted run.
- rst has priority over start on the same edge.
- err_count saturates naturally at 4; there are only 4 vectors, so no overflow is possible.
- f is treated as a synchronous input; an X on f counts as a mismatch in simulation.

Optional Feature:
- Macro: GATE_CHECK_MASK_EN.
- Defined: adds output port mismatch_mask [3:0], reset to 0 and cleared on start. At each sample edge, bit {a,b} is set if that vector mismatched. The mask holds through DONE.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- NOR gate on a/b→f, exp_tt=4'b0001, SETTLE_CYCLES=4, 1-cycle start → busy for 16 cycles, then done=1, pass=1, err_count=0; a,b walk 00,01,10,11 every 4 cycles.
- f tied 0, exp_tt=4'b0001 → err_count=1, first_err_vec=2'b00, pass=0.
- f tied 1, exp_tt=4'b0001 → err_count=3, first_err_vec=2'b01, pass=0 (with GATE_CHECK_MASK_EN: mismatch_mask=4'b1110).
- NOR gate: pulse start and set exp_tt=4'b1111 at cycle 5 of the run → both ignored; result still pass=1, done at 16 cycles after the original start.
- rst asserted at cycle 7 of a run → next edge a=b=0, busy=0, done=0, err_count=0; a fresh start then completes normally with pass=1.
- SETTLE_CYCLES=1, inverter-of-NOR (OR) on f, exp_tt=4'b0001 → done 4 cycles after start, err_count=4, first_err_vec=00 (mask 4'b1111 when enabled).
